// File: rtl/jimmy_boot_loader.sv
// Boot loader for the jimmy CPU: receives a framed program over valid/ready,
// writes it into the instruction memory, checks the checksum and sequences CPU reset.
module jimmy_boot_loader #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  input  logic              load_req,
  output logic              cpu_reset_n,
  input  logic [ADDR_W-1:0] cpu_inst_addr,
  output logic [DATA_W-1:0] cpu_inst_data,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   bytes_loaded
);

  // state       | meaning
  // ST_WAIT_LEN | waiting for the frame length byte
  // ST_LOAD     | writing payload bytes into instruction memory
  // ST_WAIT_SUM | waiting for the checksum byte
  // ST_RELEASE  | checksum good, one cycle before the CPU runs
  // ST_RUN      | CPU out of reset, fetching from memory
  // ST_ERROR    | checksum mismatch or timeout, CPU held in reset
  typedef enum logic [2:0] {
    ST_WAIT_LEN, ST_LOAD, ST_WAIT_SUM, ST_RELEASE, ST_RUN, ST_ERROR
  } state_t;

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_RELOAD = IDLE_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_sum;
  logic [IDLE_W-1:0] r_idle;
  logic [1:0]        r_err;
  logic              r_done;
  logic              r_cpu_reset_n;

  logic              w_xfer;
  logic              w_mem_we;
  logic              w_last;
  logic              w_timeout;
  logic [DATA_W-1:0] w_sum_next;
  logic [ADDR_W:0]   w_count_next;
  logic [ADDR_W:0]   w_len;

  assign s_ready      = (r_state == ST_WAIT_LEN) || (r_state == ST_LOAD) ||
                        (r_state == ST_WAIT_SUM);
  assign busy         = s_ready || (r_state == ST_RELEASE);
  assign done         = r_done;
  assign cpu_reset_n  = r_cpu_reset_n;
  assign err_code     = r_err;
  assign bytes_loaded = r_count;

  assign w_xfer       = s_valid && s_ready;
  assign w_sum_next   = r_sum + s_data;
  assign w_count_next = r_count + (ADDR_W + 1)'(1);
  assign w_last       = (w_count_next == r_len);
  assign w_timeout    = (r_idle == '0);
  // A length byte of zero stands for a full memory image.
  assign w_len        = (s_data[ADDR_W-1:0] == '0) ? (ADDR_W + 1)'(DEPTH)
                                                   : {1'b0, s_data[ADDR_W-1:0]};
  assign w_mem_we     = reset && !load_req && w_xfer && (r_state == ST_LOAD);

  // Memory has no reset so a re-load only overwrites the bytes it carries.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_addr] <= s_data;
  end

  assign cpu_inst_data = r_mem[cpu_inst_addr];

  always_ff @(posedge clk) begin
    if (!reset || load_req) begin
      r_state       <= ST_WAIT_LEN;
      r_len         <= '0;
      r_count       <= '0;
      r_addr        <= '0;
      r_sum         <= '0;
      r_idle        <= '0;
      r_err         <= 2'b00;
      r_done        <= 1'b0;
      r_cpu_reset_n <= 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_LEN: begin
          if (w_xfer) begin
            r_len   <= w_len;
            r_sum   <= s_data;
            r_addr  <= '0;
            r_count <= '0;
            r_idle  <= IDLE_RELOAD;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_xfer) begin
            r_addr  <= r_addr + ADDR_W'(1);
            r_count <= w_count_next;
            r_sum   <= w_sum_next;
            r_idle  <= IDLE_RELOAD;
            if (w_last) r_state <= ST_WAIT_SUM;
          end else if (w_timeout) begin
            r_err   <= 2'b10;
            r_state <= ST_ERROR;
          end else begin
            r_idle <= r_idle - IDLE_W'(1);
          end
        end
        ST_WAIT_SUM: begin
          if (w_xfer) begin
            if (w_sum_next == '0) begin
              r_state <= ST_RELEASE;
            end else begin
              r_err   <= 2'b01;
              r_state <= ST_ERROR;
            end
          end else if (w_timeout) begin
            r_err   <= 2'b10;
            r_state <= ST_ERROR;
          end else begin
            r_idle <= r_idle - IDLE_W'(1);
          end
        end
        ST_RELEASE: begin
          r_cpu_reset_n <= 1'b1;
          r_done        <= 1'b1;
          r_state       <= ST_RUN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/jimmy_boot_loader.md
Name: jimmy_boot_loader

Overview:
- Owns the 256x8 instruction memory of the jimmy CPU and sequences CPU start-up.
- Receives a program as a framed byte stream over a valid/ready interface and writes it into instruction memory.
- Verifies the frame checksum, then releases the CPU from reset.
- Serves CPU instruction fetches combinationally while the CPU runs; supports re-load on request, with timeout and error reporting.

Parameters:
- ADDR_W, 8, instruction address width; memory depth = 2**ADDR_W.
- DATA_W, 8, instruction/stream byte width.
- TIMEOUT_CYCLES, 1024, max idle cycles between accepted bytes inside a frame before abort; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  reset, synchronous, active-low.
- s_valid  in  1  stream byte valid.
- s_data  in  DATA_W  stream byte.
- s_ready  out  1  loader accepts a byte this cycle.
- load_req  in  1  single-cycle request: abort current activity, hold CPU in reset, start a new frame.
- cpu_reset_n  out  1  drives the CPU reset; low = CPU held in reset.
- cpu_inst_addr  in  ADDR_W  CPU program counter.
- cpu_inst_data  out  DATA_W  mem[cpu_inst_addr], combinational read.
- busy  out  1  frame in progress (WAIT_LEN, LOAD, WAIT_SUM, RELEASE).
- done  out  1  last frame loaded OK; CPU running.
- err_code  out  2  00 none, 01 checksum mismatch, 10 timeout.
- bytes_loaded  out  ADDR_W+1  payload bytes written in the current/last frame.

Behaviour:
- A byte transfer occurs on a rising edge with s_valid=1 and s_ready=1.
- Frame format: length byte L (L=0 means 256), then L payload bytes, then checksum byte K.
- The frame is valid iff (L + sum(payload) + K) mod 256 == 0, accumulated in 8 bits.
- Payload byte i is written to mem[i], starting at address 0.
- Memory is not cleared by reset or load_req; unwritten locations keep their old contents.
- States:
  - WAIT_LEN: s_ready=1. On transfer, latch L, set sum=L, set addr=0, go to LOAD.
  - LOAD: s_ready=1. On transfer, write mem[addr], update sum, increment addr and bytes_loaded. After the L-th byte go to WAIT_SUM.
  - WAIT_SUM: s_ready=1. On transfer, if sum+K==0 go to RELEASE; else go to ERROR with err_code=01.
  - RELEASE: one cycle; s_ready=0, cpu_reset_n=0. Then go to RUN.
  - RUN: s_ready=0, cpu_reset_n=1, done=1. Stays until load_req.
  - ERROR: s_ready=0, cpu_reset_n=0; err_code holds. Stays until load_req.
- cpu_reset_n is registered and equals 1 only in RUN; the CPU sees its first un-reset edge one cycle after RUN entry.
- Timeout: an idle counter runs in LOAD and WAIT_SUM and clears on every transfer.
  - When it reaches TIMEOUT_CYCLES, go to ERROR with err_code=10.
  - WAIT_LEN never times out.
- load_req in any state:
  - next state WAIT_LEN; cpu_reset_n=0 next cycle; clear done, err_code, bytes_loaded, sum and idle counter.
  - load_req has priority over a simultaneous transfer; that byte is consumed and discarded, no memory write.
- L=0 loads 256 bytes; addr wraps to 0 only after the final write; bytes_loaded reaches 256.
- Reset (reset=0 at an edge), including mid-frame:
  - state=WAIT_LEN, s_ready=1, cpu_reset_n=0, busy=1, done=0, err_code=00, bytes_loaded=0, counters=0.
- cpu_inst_data is valid in every state. Reads of an address being written in the same cycle return the old data.

Test Plan:
- Reset, send 03,80,05,A8,D0 -> mem[0..2]=80,05,A8; RELEASE for 1 cycle; then cpu_reset_n=1, done=1, err_code=00, bytes_loaded=3; cpu_inst_addr=01 gives cpu_inst_data=05.
- Same frame with K=D1 -> ERROR, err_code=01, cpu_reset_n stays 0, s_ready=0; load_req then returns to WAIT_LEN with err_code=00.
- TIMEOUT_CYCLES=16: send 04,11 then hold s_valid=0 -> ERROR with err_code=10 exactly 16 cycles after the last transfer; WAIT_LEN idle for 100 cycles gives no error.
- L=00 with 256 payload bytes of value i and a correct K -> all 256 locations written, bytes_loaded=256, RUN reached.
- In RUN, assert load_req in the same cycle as s_valid=1 with byte 55 -> cpu_reset_n=0 next cycle, state WAIT_LEN, byte 55 not taken as L, memory unchanged.
- Assert reset after 2 of 5 payload bytes, then send a full valid frame -> clean load and RUN; s_valid toggled randomly (backpressure-free source gaps) gives the same result.
